c_ram_responder: RTL and testbench



---
 rtl/c_ram_responder.sv | 106 ++++++++++
 tb/tb_c_ram_responder.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/c_ram_responder.sv
// c_ram_responder: storage end of the C-buffer RAM interface.
// A 16-entry single-port word RAM with a registered read return
// (one-cycle latency), an address echo, and a per-entry "written" bitmap
// that flags reads of entries not written since reset or the last clear.
module c_ram_responder #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ram_en,
  input  logic             ram_w_or_r,
  input  logic [3:0]       op_address,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             clear,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic [3:0]       rd_addr,
  output logic             rd_uninit,
  output logic [4:0]       wr_count,
  output logic             full
);

  // Storage array; deliberately not reset, only the bitmap says what is valid.
  logic [WIDTH-1:0] r_mem [16];

  logic [15:0]      r_written;
  logic [4:0]       r_wr_count;
  logic             r_full;

  // Read return stage
  logic [WIDTH-1:0] r_rd_data_p1;
  logic             r_vld_p1;
  logic [3:0]       r_rd_addr_p1;
  logic             r_rd_uninit_p1;

  logic             w_wr;
  logic             w_rd;
  logic             w_hit_written;
  logic [15:0]      w_sel;
  logic [15:0]      w_written_nxt;
  logic [4:0]       w_count_nxt;

  // Decode the command and compute next bitmap / count (clear first, then write).
  always_comb begin
    w_wr          = ram_en & ram_w_or_r;
    w_rd          = ram_en & ~ram_w_or_r;
    w_sel         = 16'h0001 << op_address;
    w_hit_written = r_written[op_address];
    w_written_nxt = clear ? 16'h0000 : r_written;
    if (w_wr) begin
      w_written_nxt = w_written_nxt | w_sel;
    end
    if (clear) begin
      w_count_nxt = {4'd0, w_wr};
    end else if (w_wr && !w_hit_written) begin
      w_count_nxt = r_wr_count + 5'd1;
    end else begin
      w_count_nxt = r_wr_count;
    end
  end

  // Memory write port.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[op_address] <= wr_data;
    end
  end

  // Written-entry bookkeeping: bitmap, occupancy count and full flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_written  <= 16'h0000;
      r_wr_count <= 5'd0;
      r_full     <= 1'b0;
    end else begin
      r_written  <= w_written_nxt;
      r_wr_count <= w_count_nxt;
      r_full     <= (w_count_nxt == 5'd16);
    end
  end

  // ---- stage p1: registered read return (evaluated against pre-clear bitmap) ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p1       <= 1'b0;
      r_rd_data_p1   <= '0;
      r_rd_addr_p1   <= 4'd0;
      r_rd_uninit_p1 <= 1'b0;
    end else begin
      r_vld_p1 <= w_rd;
      if (w_rd) begin
        r_rd_addr_p1   <= op_address;
        r_rd_uninit_p1 <= ~w_hit_written;
        r_rd_data_p1   <= w_hit_written ? r_mem[op_address] : '0;
      end
    end
  end

  assign rd_data   = r_rd_data_p1;
  assign rd_valid  = r_vld_p1;
  assign rd_addr   = r_rd_addr_p1;
  assign rd_uninit = r_rd_uninit_p1;
  assign wr_count  = r_wr_count;
  assign full      = r_full;

endmodule

// File: tb/tb_c_ram_responder.sv
// Self-checking bench for c_ram_responder: directed scenarios followed by
// randomized commands, compared against an array-based reference model.
module tb_c_ram_responder;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             ram_en;
  logic             ram_w_or_r;
  logic [3:0]       op_address;
  logic [WIDTH-1:0] wr_data;
  logic             clear;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic [3:0]       rd_addr;
  logic             rd_uninit;
  logic [4:0]       wr_count;
  logic             full;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [WIDTH-1:0] m_mem [16];
  bit               m_wr  [16];
  logic [WIDTH-1:0] m_rd_data;
  logic             m_rd_valid;
  logic [3:0]       m_rd_addr;
  logic             m_rd_uninit;

  c_ram_responder #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .ram_en     (ram_en),
    .ram_w_or_r (ram_w_or_r),
    .op_address (op_address),
    .wr_data    (wr_data),
    .clear      (clear),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_addr    (rd_addr),
    .rd_uninit  (rd_uninit),
    .wr_count   (wr_count),
    .full       (full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int model_count();
    int n = 0;
    for (int i = 0; i < 16; i++) n += m_wr[i] ? 1 : 0;
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_wr[i] = 1'b0;
    m_rd_data   = '0;
    m_rd_valid  = 1'b0;
    m_rd_addr   = 4'd0;
    m_rd_uninit = 1'b0;
  endtask

  task automatic check_all(input string tag);
    int n;
    n = model_count();
    chk({tag, ".rd_valid"},  {31'd0, rd_valid},  {31'd0, m_rd_valid});
    chk({tag, ".rd_data"},   rd_data,            m_rd_data);
    chk({tag, ".rd_addr"},   {28'd0, rd_addr},   {28'd0, m_rd_addr});
    chk({tag, ".rd_uninit"}, {31'd0, rd_uninit}, {31'd0, m_rd_uninit});
    chk({tag, ".wr_count"},  {27'd0, wr_count},  32'(n));
    chk({tag, ".full"},      {31'd0, full},      {31'd0, (n == 16)});
  endtask

  // Drive one command for one clock, update the model at the edge, then check.
  task automatic step(input string tag, input logic en, input logic wr,
                      input logic [3:0] addr, input logic [WIDTH-1:0] data,
                      input logic clr);
    ram_en     = en;
    ram_w_or_r = wr;
    op_address = addr;
    wr_data    = data;
    clear      = clr;
    @(posedge clk);
    if (en && !wr) begin
      m_rd_valid  = 1'b1;
      m_rd_addr   = addr;
      m_rd_uninit = !m_wr[addr];
      m_rd_data   = m_wr[addr] ? m_mem[addr] : '0;
    end else begin
      m_rd_valid = 1'b0;
    end
    if (clr) for (int i = 0; i < 16; i++) m_wr[i] = 1'b0;
    if (en && wr) begin
      m_mem[addr] = data;
      m_wr[addr]  = 1'b1;
    end
    #1;
    check_all(tag);
  endtask

  task automatic wr_cmd(input string tag, input logic [3:0] a, input logic [WIDTH-1:0] d);
    step(tag, 1'b1, 1'b1, a, d, 1'b0);
  endtask

  task automatic rd_cmd(input string tag, input logic [3:0] a);
    step(tag, 1'b1, 1'b0, a, '0, 1'b0);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 1'b0, 4'd0, '0, 1'b0);
  endtask

  initial begin
    ram_en = 0; ram_w_or_r = 0; op_address = 0; wr_data = 0; clear = 0;
    rst = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    check_all("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Uninitialised read
    rd_cmd("rd_uninit4", 4'd4);
    chk("rd_uninit4.exp_uninit", {31'd0, rd_uninit}, 32'd1);

    // Write then read-after-write at 15, strobe lasts one cycle
    wr_cmd("wr15", 4'd15, 32'hDEADBEEF);
    rd_cmd("rd15", 4'd15);
    chk("rd15.value", rd_data, 32'hDEADBEEF);
    idle("rd15.strobe_drop");
    chk("rd15.hold_data", rd_data, 32'hDEADBEEF);

    // Fill all entries, then rewrite one
    for (int i = 0; i < 16; i++) wr_cmd("fill", 4'(i), $urandom);
    chk("fill.count16", {27'd0, wr_count}, 32'd16);
    chk("fill.full", {31'd0, full}, 32'd1);
    wr_cmd("rewrite3", 4'd3, 32'h0000_3333);
    chk("rewrite3.count", {27'd0, wr_count}, 32'd16);

    // Clear together with a write
    step("clr_wr7", 1'b1, 1'b1, 4'd7, 32'h5, 1'b1);
    chk("clr_wr7.count", {27'd0, wr_count}, 32'd1);
    chk("clr_wr7.full", {31'd0, full}, 32'd0);
    rd_cmd("rd7", 4'd7);
    chk("rd7.value", rd_data, 32'h5);
    rd_cmd("rd8", 4'd8);
    chk("rd8.uninit", {31'd0, rd_uninit}, 32'd1);

    // Clear together with a read sees the pre-clear bitmap
    step("clr_rd7", 1'b1, 1'b0, 4'd7, '0, 1'b1);
    chk("clr_rd7.uninit", {31'd0, rd_uninit}, 32'd0);
    chk("clr_rd7.count", {27'd0, wr_count}, 32'd0);

    // Back-to-back reads
    wr_cmd("w0", 4'd0, 32'h10);
    wr_cmd("w1", 4'd1, 32'h11);
    wr_cmd("w2", 4'd2, 32'h12);
    rd_cmd("b2b0", 4'd0);
    chk("b2b0.value", rd_data, 32'h10);
    rd_cmd("b2b1", 4'd1);
    chk("b2b1.value", rd_data, 32'h11);
    rd_cmd("b2b2", 4'd2);
    chk("b2b2.value", rd_data, 32'h12);
    idle("b2b.end");

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      step("rand", ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
           4'($urandom_range(0, 15)), $urandom, ($urandom_range(0, 29) == 0));
    end

    // Reset arriving while a read is in flight
    ram_en = 1'b1; ram_w_or_r = 1'b0; op_address = 4'd1; wr_data = '0; clear = 1'b0;
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    check_all("rst_mid");
    @(posedge clk);
    #1;
    check_all("rst_mid.held");
    ram_en = 1'b0;
    #2;
    rst = 1'b0;
    idle("rst_mid.after");
    chk("rst_mid.count", {27'd0, wr_count}, 32'd0);
    rd_cmd("rst_mid.rd1", 4'd1);
    chk("rst_mid.rd1_uninit", {31'd0, rd_uninit}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
